// File: rtl/proc_pkg.sv
// Shared definitions for the four-step processor and its instruction feeder:
// opcode values, instruction field positions and the feeder state encoding.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;
  localparam int RX_HI  = 5;
  localparam int RX_LO  = 3;
  localparam int RY_HI  = 2;
  localparam int RY_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_IMM   = 2'd2,
    ST_EXEC  = 2'd3
  } feeder_state_t;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/feeder_ram.sv
// Program memory for the instruction feeder: one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module feeder_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 9
) (
  input  logic          Clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Store a program word on the write strobe.
  always_ff @(posedge Clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/proc_instr_feeder.sv
// Instruction feeder: steps a program counter through a loadable program
// memory and presents each word to the processor in step with its Done
// handshake. The instruction word goes out in processor T0, and the mvi
// immediate goes out in T1. A missing Done raises a sticky error.
module proc_instr_feeder
  import proc_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Done,
  input  logic             LdEn,
  input  logic [AW-1:0]    LdAddr,
  input  logic [8:0]       LdData,
  output logic [8:0]       DIN,
  output logic             Run,
  output logic             Busy,
  output logic             Err,
  output logic [AW-1:0]    PC,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

  feeder_state_t    r_state;
  logic [AW-1:0]    r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic [WW-1:0]    r_wait;
  logic [8:0]       r_word;
  logic             r_err;
  logic             r_pending;
  logic             r_stop_req;

  logic [8:0]       w_rdata;
  logic [AW-1:0]    w_pc_inc;
  logic             w_we;
  logic             w_stop;

  // Loading is only safe while nothing is executing or about to execute.
  assign w_we     = LdEn && (r_state == ST_IDLE) && !r_pending;
  assign w_pc_inc = (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
  // A Stop arriving in the very cycle of Done is honoured at that Done.
  assign w_stop   = r_stop_req | Stop;

  feeder_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (9)
  ) u_ram (
    .Clock  (Clock),
    .i_we   (w_we),
    .i_waddr(LdAddr),
    .i_wdata(LdData),
    .i_raddr(r_pc),
    .o_rdata(w_rdata)
  );

  // Sequencer: start handshake, fetch/immediate/execute stepping, timeout.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
      r_pending  <= 1'b0;
      r_stop_req <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The processor idles on mv R0,R0; leaving on its Done puts
          // FETCH exactly on the processor's next T0.
          if (r_pending && Done) begin
            r_state   <= ST_FETCH;
            r_pending <= 1'b0;
          end else if (Stop) begin
            r_pending <= 1'b0;
          end else if (Start) begin
            r_pending <= 1'b1;
            r_err     <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_word <= w_rdata;
          r_pc   <= w_pc_inc;
          r_wait <= '0;
          r_state <= (opcode_of(w_rdata) == OP_MVI) ? ST_IMM : ST_EXEC;
          if (Stop) begin
            r_stop_req <= 1'b1;
          end
        end
        ST_IMM, ST_EXEC: begin
          if (Done) begin
            if (r_state == ST_IMM) begin
              r_pc <= w_pc_inc;
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_stop) begin
              r_state    <= ST_IDLE;
              r_stop_req <= 1'b0;
            end else begin
              r_state <= ST_FETCH;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_err      <= 1'b1;
            r_state    <= ST_IDLE;
            r_stop_req <= 1'b0;
          end else begin
            r_wait <= r_wait + 1'b1;
            if (Stop) begin
              r_stop_req <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Word driven to the processor: idle mv R0,R0, the live memory word during
  // fetch and immediate, and the held instruction while it executes.
  always_comb begin
    DIN = 9'h000;
    case (r_state)
      ST_FETCH, ST_IMM: DIN = w_rdata;
      ST_EXEC:          DIN = r_word;
      default:          DIN = 9'h000;
    endcase
  end

  assign Run        = (r_state != ST_IDLE);
  assign Busy       = Run | r_pending;
  assign Err        = r_err;
  assign PC         = r_pc;
  assign InstrCount = r_cnt;

endmodule

// File: tb/tb_proc_instr_feeder.sv
// Bench for proc_instr_feeder: a small four-step processor model consumes DIN
// and produces Done, an instruction-level model predicts every feeder output
// each cycle, and directed scenarios pin the model with literal values.
module tb_proc_instr_feeder;
  import proc_pkg::*;

  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;

  logic             Clock  = 1'b0;
  logic             Resetn = 1'b1;
  logic             Start  = 1'b0;
  logic             Stop   = 1'b0;
  logic             LdEn   = 1'b0;
  logic [AW-1:0]    LdAddr = '0;
  logic [8:0]       LdData = '0;
  logic             Done;
  logic [8:0]       DIN;
  logic             Run;
  logic             Busy;
  logic             Err;
  logic [AW-1:0]    PC;
  logic [CNT_W-1:0] InstrCount;

  int   checks   = 0;
  int   failures = 0;
  logic stub     = 1'b0;
  logic cap_en   = 1'b0;
  logic [8:0] seen [$];
  logic [8:0] prog [DEPTH];

  always #5 Clock = ~Clock;

  proc_instr_feeder #(
    .DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop), .Done(Done),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData), .DIN(DIN), .Run(Run),
    .Busy(Busy), .Err(Err), .PC(PC), .InstrCount(InstrCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- processor model (drives Done) ----------------
  logic [1:0] p_t;
  logic [8:0] p_ir, p_a, p_g;
  logic [8:0] p_r [8];
  logic       p_done;
  logic [2:0] p_op;

  assign p_op   = p_ir[8:6];
  assign p_done = ((p_t == 2'd1) && !(p_op == OP_ADD || p_op == OP_SUB)) || (p_t == 2'd3);
  assign Done   = p_done & ~stub;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p_t  <= 2'd0;
      p_ir <= 9'h000;
      p_a  <= 9'h000;
      p_g  <= 9'h000;
      for (int i = 0; i < 8; i++) p_r[i] <= 9'h000;
    end else begin
      case (p_t)
        2'd0: begin
          p_ir <= DIN;
          p_t  <= 2'd1;
        end
        2'd1: begin
          if (p_op == OP_MVI) begin
            p_r[p_ir[5:3]] <= DIN;
            p_t <= 2'd0;
          end else if (p_op == OP_ADD || p_op == OP_SUB) begin
            p_a <= p_r[p_ir[5:3]];
            p_t <= 2'd2;
          end else begin
            p_r[p_ir[5:3]] <= p_r[p_ir[2:0]];
            p_t <= 2'd0;
          end
        end
        2'd2: begin
          p_g <= (p_op == OP_ADD) ? p_a + p_r[p_ir[2:0]] : p_a - p_r[p_ir[2:0]];
          p_t <= 2'd3;
        end
        default: begin
          p_r[p_ir[5:3]] <= p_g;
          p_t <= 2'd0;
        end
      endcase
    end
  end

  // ---------------- instruction-level feeder model ----------------
  // m_step: 0 = the instruction word is being offered, 1 = the instruction
  // is in flight waiting for its Done.
  logic [8:0]       m_mem [DEPTH];
  logic             m_run, m_pending, m_stop, m_err, m_mvi;
  int               m_step, m_wait;
  logic [AW-1:0]    m_pc;
  logic [CNT_W-1:0] m_cnt;
  logic [8:0]       m_word;
  logic [8:0]       m_din;

  task automatic model_reset();
    m_run = 0; m_pending = 0; m_stop = 0; m_err = 0; m_mvi = 0;
    m_step = 0; m_wait = 0; m_pc = '0; m_cnt = '0; m_word = '0;
  endtask

  task automatic model_step();
    if (!m_run) begin
      if (LdEn && !m_pending) m_mem[LdAddr] = LdData;
      if (m_pending && Done) begin
        m_run = 1; m_pending = 0; m_step = 0;
      end else if (Stop) begin
        m_pending = 0;
      end else if (Start) begin
        m_pending = 1; m_err = 0;
      end
    end else if (m_step == 0) begin
      m_word = m_mem[m_pc];
      m_mvi  = (m_word[8:6] == OP_MVI);
      m_pc   = m_pc + 1'b1;
      m_step = 1;
      m_wait = 0;
      if (Stop) m_stop = 1;
    end else if (Done) begin
      if (m_mvi) m_pc = m_pc + 1'b1;
      m_cnt = m_cnt + 1'b1;
      if (m_stop || Stop) begin
        m_run = 0; m_stop = 0;
      end else begin
        m_step = 0;
      end
    end else begin
      m_wait++;
      if (m_wait == MAX_WAIT) begin
        m_err = 1; m_run = 0; m_stop = 0;
      end else if (Stop) begin
        m_stop = 1;
      end
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge Clock) begin
    if (!Resetn) model_reset();
    if (!m_run)                  m_din = 9'h000;
    else if (m_step == 0 || m_mvi) m_din = m_mem[m_pc];
    else                          m_din = m_word;
    chk("cycle{DIN,Run,Busy,Err,PC,Cnt}",
        64'({DIN, Run, Busy, Err, PC, InstrCount}),
        64'({m_din, m_run, m_run | m_pending, m_err, m_pc, m_cnt}));
    if (Resetn) model_step();
  end

  // Words offered while the processor is in T0, or in T1 of mvi.
  always @(negedge Clock) begin
    if (cap_en && Resetn && Run && (p_t == 2'd0 || (p_t == 2'd1 && p_op == OP_MVI)))
      seen.push_back(DIN);
  end

  // ---------------- stimulus helpers (start/end at posedge+1) ----------------
  task automatic do_reset();
    Resetn = 1'b0;
    stub   = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b1;
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      LdEn = 1'b1; LdAddr = AW'(i); LdData = prog[i];
      @(posedge Clock); #1;
    end
    LdEn = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_din(input logic [8:0] v, input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge Clock);
      if (Run === 1'b1 && DIN === v) found = 1;
    end
    chk(name, 64'(found), 64'(1));
    @(posedge Clock); #1;
  endtask

  // Ends at the negedge where Run is first seen low.
  task automatic wait_idle(input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge Clock);
      if (Run === 1'b0) found = 1;
    end
    chk(name, 64'(found), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int runs;

    // Reset state.
    #2 Resetn = 1'b0;
    @(negedge Clock);
    chk("reset_state", 64'({DIN, Run, Busy, Err, PC, InstrCount}), 64'(0));
    @(posedge Clock); #1;
    Resetn = 1'b1;

    // Load and run, with Start issued on a Done=0 cycle.
    for (int i = 0; i < DEPTH; i++) prog[i] = 9'h000;
    prog[0] = 9'h040; prog[1] = 9'h005; prog[2] = 9'h008; prog[3] = 9'h081;
    load_all();
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) got = 1;
    end
    chk("idle_done_pulse", 64'(got), 64'(1));
    @(posedge Clock); #1;
    seen.delete();
    cap_en = 1'b1;
    Start  = 1'b1;
    @(negedge Clock);
    chk("align_start{Run,Busy,Done}", 64'({Run, Busy, Done}), 64'(3'b000));
    @(posedge Clock); #1;
    Start = 1'b0;
    @(negedge Clock);
    chk("align_wait{Run,Busy,Done}", 64'({Run, Busy, Done}), 64'(3'b011));
    @(negedge Clock);
    chk("align_fetch{Run,DIN}", 64'({Run, DIN}), 64'({1'b1, 9'h040}));
    wait_din(9'h081, 20, "reach_add");
    Stop = 1'b1;
    @(posedge Clock); #1;
    Stop = 1'b0;
    wait_idle(10, "add_stops");
    chk("prog_R0", 64'(p_r[0]), 64'(10));
    chk("prog_R1", 64'(p_r[1]), 64'(5));
    chk("prog_PC", 64'(PC), 64'(4));
    chk("prog_cnt", 64'(InstrCount), 64'(3));
    cap_en = 1'b0;
    chk("din_seq_len", 64'(seen.size()), 64'(4));
    chk("din_seq0", 64'(seen[0]), 64'(9'h040));
    chk("din_seq1", 64'(seen[1]), 64'(9'h005));
    chk("din_seq2", 64'(seen[2]), 64'(9'h008));
    chk("din_seq3", 64'(seen[3]), 64'(9'h081));
    @(posedge Clock); #1;

    // Stop during EXEC of the second instruction.
    do_reset();
    pulse_start();
    wait_din(9'h008, 20, "reach_mv");
    Stop = 1'b1;
    @(negedge Clock);
    @(posedge Clock); #1;
    Stop = 1'b0;
    @(negedge Clock);
    chk("stop{Run,PC,Cnt}", 64'({Run, PC, InstrCount}), 64'({1'b0, 5'd3, 16'd2}));
    runs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (Run !== 1'b0) runs++;
    end
    chk("no_refetch", 64'(runs), 64'(0));
    @(posedge Clock); #1;

    // Reset asserted mid-run takes effect at once.
    pulse_start();
    repeat (6) @(posedge Clock);
    #1;
    chk("run_before_reset", 64'(Run), 64'(1));
    #1 Resetn = 1'b0;
    #1;
    chk("async_reset", 64'({DIN, Run, Busy, Err, PC, InstrCount}), 64'(0));
    @(posedge Clock); #1;
    Resetn = 1'b1;

    // Done timeout during an add.
    for (int i = 0; i < DEPTH; i++) prog[i] = 9'h000;
    prog[0] = 9'h081;
    load_all();
    pulse_start();
    wait_din(9'h081, 10, "reach_add_to");
    stub = 1'b1;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(negedge Clock);
      chk($sformatf("timeout_wait%0d{Run,Err}", k), 64'({Run, Err}), 64'(2'b10));
    end
    @(negedge Clock);
    chk("timeout{Run,Err,PC}", 64'({Run, Err, PC}), 64'({1'b0, 1'b1, 5'd1}));
    @(posedge Clock); #1;
    pulse_start();
    @(negedge Clock);
    chk("err_clear{Err,Busy}", 64'({Err, Busy}), 64'(2'b01));
    @(posedge Clock); #1;
    Stop = 1'b1;
    @(posedge Clock); #1;
    Stop = 1'b0;
    @(negedge Clock);
    chk("stop_idle_pending", 64'(Busy), 64'(0));
    @(posedge Clock); #1;

    // PC wrap through an mvi at DEPTH-1, plus load lockout while running.
    do_reset();
    for (int i = 0; i < DEPTH; i++) prog[i] = 9'h000;
    prog[0]  = 9'h00F;
    prog[31] = 9'h050;
    load_all();
    pulse_start();
    repeat (4) @(posedge Clock);
    #1;
    chk("lock_running", 64'(Run), 64'(1));
    LdEn = 1'b1; LdAddr = 5'd31; LdData = 9'h000;
    @(posedge Clock); #1;
    LdEn = 1'b0;
    wait_din(9'h050, 200, "reach_mvi_31");
    Stop = 1'b1;
    @(negedge Clock);
    chk("wrap_imm_din", 64'(DIN), 64'(9'h00F));
    @(posedge Clock); #1;
    Stop = 1'b0;
    @(negedge Clock);
    chk("wrap{Run,PC,Cnt}", 64'({Run, PC, InstrCount}), 64'({1'b0, 5'd1, 16'd32}));
    chk("wrap_R2", 64'(p_r[2]), 64'(15));
    @(posedge Clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
